// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Optional ARB_PERF_CNT_EN adds saturating stall-cycle counters if_wait_cnt / dm_wait_cnt.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       if_wait_cnt,
  output logic [31:0]       dm_wait_cnt,
`endif
  output logic              busy
);

  localparam logic [3:0] LAT4    = 4'(MEM_LAT);
  localparam logic [3:0] STARVE4 = 4'(STARVE_MAX);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       owner_dm;
  logic       op_we;

  logic expiry, arb_ok, if_pend, dm_pend, if_wins, grant_if, grant_dm;

  // The last latency cycle doubles as the arbitration slot for the next access.
  assign expiry = (state == BUSY) && (lat_cnt == 4'd1);
  assign arb_ok = (state == IDLE) || expiry;

  // A requester completing now (or pulsing valid this cycle) is not a new request.
  assign if_pend  = if_req & ~if_valid & ~(expiry & ~owner_dm);
  assign dm_pend  = dm_req & ~dm_valid & ~(expiry & owner_dm);
  assign if_wins  = if_pend & (~dm_pend | (starve_cnt == STARVE4));
  assign grant_if = arb_ok & if_wins;
  assign grant_dm = arb_ok & dm_pend & ~if_wins;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      op_we      <= 1'b0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_rdata   <= '0;
      dm_valid   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      if (expiry) begin
        if (owner_dm) begin
          dm_valid <= 1'b1;
          if (!op_we) dm_rdata <= mem_rdata;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end

      if (grant_if || grant_dm) begin
        state     <= BUSY;
        lat_cnt   <= LAT4;
        owner_dm  <= grant_dm;
        op_we     <= grant_dm & dm_we;
        mem_en    <= 1'b1;
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
        busy      <= 1'b1;
      end else if (expiry) begin
        state   <= IDLE;
        lat_cnt <= '0;
        busy    <= 1'b1;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 4'd1;
        busy    <= 1'b1;
      end else begin
        busy <= 1'b0;
      end

      // Fetch starvation tracking: only a real loss while fetch is pending counts.
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_dm && if_pend && (starve_cnt != STARVE4)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_wait_cnt <= '0;
      dm_wait_cnt <= '0;
    end else begin
      if (stall_if && (if_wait_cnt != '1)) if_wait_cnt <= if_wait_cnt + 32'd1;
      if (stall_mem && (dm_wait_cnt != '1)) dm_wait_cnt <= dm_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table, hand sequences and random traffic
// against a time-based transaction model.
module tb_unified_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam int NV   = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem, busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_wait_cnt, dm_wait_cnt;
`endif

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef ARB_PERF_CNT_EN
    .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_val;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[NV];

  // Memory: a few fixed words from the vector table, hash elsewhere.
  logic [31:0] ov_addr[NV];
  logic [31:0] ov_data[NV];
  logic [31:0] lat_addr = 32'h0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    for (int i = 0; i < NV; i++) if (ov_addr[i] == a) return ov_data[i];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) if (mem_en) lat_addr <= mem_addr;
  assign mem_rdata = mem_f(mem_en ? mem_addr : lat_addr);

  // Reference model: each requester's latest transaction as grant/done cycle numbers.
  int          c;
  int          g_if, d_if, g_dm, d_dm, last_grant, last_done, starve;
  logic [31:0] a_if, a_dm, wd_dm, e_addr, e_wdata, e_if_rd, e_dm_rd;
  logic        we_dm, e_we, last_ev_if, last_ev_dm;
  int          checks = 0;
  int          failures = 0;

  logic        s_if_valid, s_dm_valid, s_mem_en, s_mem_we, s_busy;
  logic [31:0] s_if_rd, s_dm_rd, s_mem_addr, s_mem_wdata;

  task automatic model_clear();
    g_if = -100; d_if = -100; g_dm = -100; d_dm = -100;
    last_grant = -100; last_done = -100; starve = 0;
    e_if_rd = '0; e_dm_rd = '0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    we_dm = 1'b0; a_if = '0; a_dm = '0; wd_dm = '0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, c, act, exp);
    end
  endtask

  task automatic step();
    logic ev_if, ev_dm, e_en, e_busy, ifp, dmp;
    @(negedge clk);
    s_if_valid = if_valid; s_dm_valid = dm_valid; s_mem_en = mem_en; s_mem_we = mem_we;
    s_busy = busy; s_if_rd = if_rdata; s_dm_rd = dm_rdata;
    s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    ev_if = (d_if == c);
    ev_dm = (d_dm == c);
    if (ev_if) e_if_rd = mem_f(a_if);
    if (ev_dm && !we_dm) e_dm_rd = mem_f(a_dm);
    e_en   = (last_grant == c);
    e_busy = ((g_if <= c) && (c <= d_if)) || ((g_dm <= c) && (c <= d_dm));
    chk("if_valid", 64'(if_valid), 64'(ev_if));
    chk("dm_valid", 64'(dm_valid), 64'(ev_dm));
    chk("if_rdata", 64'(if_rdata), 64'(e_if_rd));
    chk("dm_rdata", 64'(dm_rdata), 64'(e_dm_rd));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_en & e_we));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("stall_if", 64'(stall_if), 64'(if_req & ~ev_if));
    chk("stall_mem", 64'(stall_mem), 64'(dm_req & ~ev_dm));
    if (e_en) begin
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    end
    last_ev_if = ev_if;
    last_ev_dm = ev_dm;
    // Next grant: allowed once the outstanding access is in its last latency cycle or done.
    if (!reset && (c >= last_done - 1)) begin
      ifp = if_req && !((d_if == c) || (d_if == c + 1));
      dmp = dm_req && !((d_dm == c) || (d_dm == c + 1));
      if (ifp && (!dmp || starve == SMAX)) begin
        g_if = c + 1; d_if = c + 1 + LAT; a_if = if_addr; starve = 0;
        last_grant = c + 1; last_done = d_if;
        e_we = 1'b0; e_addr = if_addr;
      end else if (dmp) begin
        g_dm = c + 1; d_dm = c + 1 + LAT; a_dm = dm_addr; we_dm = dm_we; wd_dm = dm_wdata;
        if (ifp && starve < SMAX) starve++;
        last_grant = c + 1; last_done = d_dm;
        e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
      end
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0;
    model_clear();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int lat, cnt;
    logic saw;
    logic [7:0] iv, dv, me;
    logic [31:0] cap_addr, cap_wdata;
    logic cap_we;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'h8C22_0004, 3, 32'h8C22_0004};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          32'h1122_3344, 3, 32'h1122_3344};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF,  32'h0BAD_F00D, 3, 32'h1122_3344};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'hCAFE_BABE, 3, 32'hCAFE_BABE};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,          32'h0000_0001, 3, 32'h0000_0001};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0007, 32'h1234_5678,  32'h7777_7777, 3, 32'h0000_0001};
    for (int i = 0; i < NV; i++) begin
      ov_addr[i] = vecs[i].addr;
      ov_data[i] = vecs[i].mem_val;
    end

    c = 0;
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    last_ev_if = 1'b0; last_ev_dm = 1'b0;
    do_reset();

    // Single isolated transactions from the vector table.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_dm) begin
        dm_req = 1'b1; dm_we = vecs[i].we; dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      lat = -1;
      cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (s_mem_en) begin cap_addr = s_mem_addr; cap_wdata = s_mem_wdata; cap_we = s_mem_we; end
        if (vecs[i].is_dm ? s_dm_valid : s_if_valid) begin lat = k; break; end
      end
      chk("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
      chk("vec_rdata", 64'(vecs[i].is_dm ? s_dm_rd : s_if_rd), 64'(vecs[i].exp_rdata));
      chk("vec_mem_addr", 64'(cap_addr), 64'(vecs[i].addr));
      chk("vec_mem_we", 64'(cap_we), 64'(vecs[i].we));
      if (vecs[i].we) chk("vec_mem_wdata", 64'(cap_wdata), 64'(vecs[i].wdata));
      if_req = 1'b0; dm_req = 1'b0;
      step();
      step();
    end

    // Simultaneous fetch and load: data first, fetch granted on the data expiry.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100;
    iv = '0; dv = '0; me = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      iv[k] = s_if_valid; dv[k] = s_dm_valid; me[k] = s_mem_en;
      if (s_dm_valid) dm_req = 1'b0;
      if (s_if_valid) if_req = 1'b0;
    end
    chk("simul_dm_valid", 64'(dv), 64'(8'b0000_1000));
    chk("simul_if_valid", 64'(iv), 64'(8'b0010_0000));
    chk("simul_mem_en", 64'(me), 64'(8'b0000_1010));
`ifdef ARB_PERF_CNT_EN
    chk("perf_dm_wait", 64'(dm_wait_cnt), 64'd3);
    chk("perf_if_wait", 64'(if_wait_cnt), 64'd5);
`endif

    // Reset one cycle after issue abandons the load.
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    step();
    step();
    reset = 1'b1;
    model_clear();
    dm_req = 1'b0;
    step();
    chk("rst_mem_en", 64'(s_mem_en), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_dm_rdata", 64'(s_dm_rd), 64'd0);
    reset = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      saw = saw | s_dm_valid;
    end
    chk("rst_no_valid", 64'(saw), 64'd0);

    // Random traffic, including occasional early request drops.
    cnt = 0;
    for (int n = 0; n < 800; n++) begin
      if (!if_req || last_ev_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 63) == 0) begin
        if_req = 1'b0;
      end
      if (!dm_req || last_ev_dm) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end else if ($urandom_range(0, 63) == 0) begin
        dm_req = 1'b0;
      end
      step();
      if (s_mem_en) cnt++;
    end
    chk("rand_activity", 64'(cnt > 50), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
